tt4_preimage_enum: RTL and testbench
====================================

Name: tt4_preimage_enum

Overview:
- Inverse-direction companion to the 4-input cut evaluators in the power sub-circuit flow.
- A cut evaluator maps an input vector to one output bit. This block takes a cut truth table plus a target output value and streams every input vector (minterm) that produces that value.
- Used by the switching-activity harness to generate stimulus that exercises a chosen output polarity.
- Sits between the request queue and the stimulus/activity counters, with a valid/ready handshake on both sides.

Parameters:
- K, 4, number of cut inputs; truth-table width is 2**K; legal range 2..6.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_tt  input  2**K  truth table; bit m = output for input vector m
- req_target  input  1  output value whose preimage is enumerated
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- out_vec  output  K  matching input vector
- out_last  output  1  final beat of this request
- out_none  output  1  preimage empty; beat carries no vector
- out_count  output  K+1  number of matches; meaningful only when out_last=1

Behaviour:
- States: IDLE, SCAN, HOLD.
- Reset (synchronous, active-high): state=IDLE; req_ready=1; out_valid=0; out_vec=0; out_last=0; out_none=0; out_count=0; scan index=0; match counter=0. Reset mid-scan abandons the request with no further beats; req_ready=1 in the cycle after reset deasserts.
- IDLE, on req_valid&req_ready:
  - Register mask = req_tt XNOR {2**K{req_target}}.
  - Build scan-order mask smask[i] = mask[ord(i)], where ord(i)=i by default.
  - Clear index and counter, go to SCAN.
  - req_ready drops the next cycle.
- Empty mask: go straight to HOLD with one beat: out_none=1, out_last=1, out_vec=0, out_count=0.
- SCAN: one index per cycle.
  - smask[i]=0: increment i, no beat.
  - smask[i]=1: load out_vec=ord(i); out_last = ~|(smask>>(i+1)); out_count = counter+1 when last. Increment counter, go to HOLD with out_valid=1.
- HOLD: out_* held stable while out_ready=0.
  - On handshake, not last: i+1 and back to SCAN.
  - On handshake, last: go to IDLE.
- Timing:
  - First beat for scan position p appears p+1 cycles after request acceptance (registered output).
  - A matching minterm costs one HOLD cycle plus one SCAN cycle.
  - Worst case (tt all-match, K=4) is 32 cycles under continuous out_ready.
- Index is K+1 bits so position 2**K-1 never wraps. Counter saturation is impossible because count ≤ 2**K.
- req_valid outside IDLE is ignored, with no side effect.
- out_valid never rises in the cycle a request is accepted.

Optional Feature:
- TT4_PREIMAGE_GRAY_ORDER_EN
  - Defined: ord(i) = i ^ (i>>1), i.e. beats are emitted in reflected-Gray order, minimising input toggles between consecutive stimulus vectors. out_last and out_count semantics are unchanged.
  - Undefined: ord(i) = i (ascending binary order), and the permutation logic is absent.

Decomposition:
- Package tt_enum_pkg holds:
  - state enum {IDLE, SCAN, HOLD}
  - K default constant
  - function gray_of(i)
  - function popcount (bench use)
- One sub-module, tt_scan_permute: combinational mask[2**K] -> smask[2**K] reordering. It is identity when the macro is off.

Test Plan:
- tt=16'h0000, target=1 -> single beat out_none=1, out_last=1, out_count=0, out_vec=0; req_ready high again the cycle after handshake.
- tt=16'h8001, target=1, out_ready=1 -> out_vec=0 (last=0), then out_vec=15 (last=1, count=2); first beat 1 cycle after acceptance.
- tt=16'h8001, target=0 -> 14 beats, vectors 1..14 ascending; last on 14; count=14.
- Gray enabled: tt=16'h000C, target=1 -> out_vec=3 then out_vec=2 (last, count=2). Gray disabled -> out_vec=2 then 3.
- Backpressure: tt=16'hFFFF, out_ready low for 5 cycles on beat 3 -> out_vec=3 and flags stable throughout; total 16 beats; count=16.
- Reset mid-scan: rst pulsed while in HOLD of tt=16'hFFFF -> out_valid=0 and req_ready=1 the next cycle; a new request tt=16'h0001, target=1 yields a single beat out_vec=0, last=1, count=1.

Source files
------------

// File: rtl/tt_enum_pkg.sv
// Shared definitions for the truth-table preimage enumerator.
//   state_t    : controller states IDLE / SCAN / HOLD
//   K_DEF      : default number of cut inputs
//   gray_of()  : reflected-Gray code of an index
//   popcount() : number of set bits in a truth-table mask
package tt_enum_pkg;

  localparam int K_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [7:0] gray_of(input logic [7:0] i);
    return i ^ (i >> 1);
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int b = 0; b < 64; b++) n += int'(v[b]);
    return n;
  endfunction

endpackage

// File: rtl/tt_scan_permute.sv
// Reorders a truth-table mask into scan order: smask[i] = mask[ord(i)].
// Optional macro TT4_PREIMAGE_GRAY_ORDER_EN selects ord(i) = i ^ (i>>1);
// otherwise ord(i) = i and this block is plain wiring.
// Ports:
//   mask  : 2**K-bit mask, bit m set when vector m matches the target
//   smask : the same mask in scan order
module tt_scan_permute
  import tt_enum_pkg::*;
#(
  parameter int K = K_DEF
) (
  input  logic [(1<<K)-1:0] mask,
  output logic [(1<<K)-1:0] smask
);

`ifdef TT4_PREIMAGE_GRAY_ORDER_EN
  for (genvar i = 0; i < (1 << K); i++) begin : g_perm
    localparam logic [7:0] G = gray_of(8'(i));
    assign smask[i] = mask[G[K-1:0]];
  end
`else
  assign smask = mask;
`endif

endmodule

// File: rtl/tt4_preimage_enum.sv
// Streams every input vector of a K-input cut truth table whose output
// equals a requested target value. One request in, one beat per matching
// vector out (or a single "none" beat when no vector matches).
// Optional macro TT4_PREIMAGE_GRAY_ORDER_EN emits vectors in reflected-Gray
// order instead of ascending order.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_tt, req_target    : truth table and target output polarity
//   out_valid/out_ready   : output beat handshake
//   out_vec               : matching input vector
//   out_last              : final beat of the request
//   out_none              : empty preimage, beat carries no vector
//   out_count             : number of matches, valid with out_last
module tt4_preimage_enum
  import tt_enum_pkg::*;
#(
  parameter int K = K_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [(1<<K)-1:0] req_tt,
  input  logic              req_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K-1:0]      out_vec,
  output logic              out_last,
  output logic              out_none,
  output logic [K:0]        out_count
);

  localparam int TT_W = 1 << K;

  state_t          state, state_n;
  logic [TT_W-1:0] mask, mask_n, smask, req_mask;
  // One extra bit so the index can step past the final position.
  logic [K:0]      idx, idx_n;
  logic [K:0]      cnt, cnt_n;
  logic            valid_n, last_n, none_n, is_last;
  logic [K-1:0]    vec_n, ord_idx;
  logic [K:0]      count_n;

  assign req_mask  = req_tt ~^ {TT_W{req_target}};
  assign req_ready = (state == IDLE);

  tt_scan_permute #(.K(K)) u_perm (
    .mask  (mask),
    .smask (smask)
  );

`ifdef TT4_PREIMAGE_GRAY_ORDER_EN
  assign ord_idx = idx[K-1:0] ^ (idx[K-1:0] >> 1);
`else
  assign ord_idx = idx[K-1:0];
`endif

  // No further scan-order bits set beyond the current position.
  assign is_last = ~|(smask >> (idx + 1'b1));

  always_comb begin
    state_n = state;
    mask_n  = mask;
    idx_n   = idx;
    cnt_n   = cnt;
    valid_n = out_valid;
    vec_n   = out_vec;
    last_n  = out_last;
    none_n  = out_none;
    count_n = out_count;
    case (state)
      IDLE: begin
        if (req_valid) begin
          mask_n = req_mask;
          idx_n  = '0;
          cnt_n  = '0;
          if (req_mask == '0) begin
            state_n = HOLD;
            valid_n = 1'b1;
            none_n  = 1'b1;
            last_n  = 1'b1;
            vec_n   = '0;
            count_n = '0;
          end else begin
            state_n = SCAN;
            valid_n = 1'b0;
            none_n  = 1'b0;
          end
        end
      end
      SCAN: begin
        if (idx[K]) begin
          state_n = IDLE;
        end else if (smask[idx[K-1:0]]) begin
          state_n = HOLD;
          valid_n = 1'b1;
          none_n  = 1'b0;
          vec_n   = ord_idx;
          last_n  = is_last;
          count_n = is_last ? cnt + 1'b1 : '0;
          cnt_n   = cnt + 1'b1;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_n = 1'b0;
          if (out_last) begin
            state_n = IDLE;
          end else begin
            state_n = SCAN;
            idx_n   = idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    mask <= mask_n;
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
      out_count <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      out_valid <= valid_n;
      out_vec   <= vec_n;
      out_last  <= last_n;
      out_none  <= none_n;
      out_count <= count_n;
    end
  end

endmodule

// File: tb/tb_tt4_preimage_enum.sv
module tb_tt4_preimage_enum;
  import tt_enum_pkg::*;

  localparam int K = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_tt;
  logic        req_target;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_vec;
  logic        out_last;
  logic        out_none;
  logic [4:0]  out_count;

  tt4_preimage_enum #(.K(K)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_tt     (req_tt),
    .req_target (req_target),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .out_last   (out_last),
    .out_none   (out_none),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] vec;
    logic       last;
    logic       none;
    logic [4:0] count;
  } beat_t;

  beat_t q[$];
  int total = 0;
  int bad   = 0;
  int beats = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ord(input int i);
    logic [7:0] g;
`ifdef TT4_PREIMAGE_GRAY_ORDER_EN
    g = gray_of(8'(i));
`else
    g = 8'(i);
`endif
    return g[3:0];
  endfunction

  // Expected beat stream for one request.
  task automatic push_model(input logic [15:0] tt, input logic target);
    logic [15:0] m;
    logic [3:0]  o;
    int n, seen;
    beat_t b;
    m = target ? tt : ~tt;
    n = popcount(64'(m));
    if (n == 0) begin
      b = '{vec: 4'd0, last: 1'b1, none: 1'b1, count: 5'd0};
      q.push_back(b);
    end else begin
      seen = 0;
      for (int i = 0; i < 16; i++) begin
        o = ord(i);
        if (m[o]) begin
          seen++;
          b.vec   = o;
          b.last  = (seen == n);
          b.none  = 1'b0;
          b.count = (seen == n) ? 5'(n) : 5'd0;
          q.push_back(b);
        end
      end
    end
  endtask

  // Output monitor: scoreboard pop on handshake, stability check while stalled.
  logic       stalled = 1'b0;
  logic [3:0] h_vec;
  logic       h_last, h_none;
  beat_t      e;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_vec",   32'(out_vec),   32'(h_vec));
        chk("stall_flags", {30'd0, out_last, out_none}, {30'd0, h_last, h_none});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_beat", 32'(out_vec), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("beat_vec",  32'(out_vec),  32'(e.vec));
          chk("beat_last", 32'(out_last), 32'(e.last));
          chk("beat_none", 32'(out_none), 32'(e.none));
          if (e.last) chk("beat_count", 32'(out_count), 32'(e.count));
          beats++;
        end
      end
      stalled = out_valid && !out_ready;
      h_vec   = out_vec;
      h_last  = out_last;
      h_none  = out_none;
    end
  end

  task automatic send_req(input logic [15:0] tt, input logic target);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    push_model(tt, target);
    req_tt     = tt;
    req_target = target;
    req_valid  = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0 || out_valid) chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_tt = '0; req_target = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_vec",   32'(out_vec),   32'd0);
    chk("rst_flags",     {30'd0, out_last, out_none}, 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty preimage: single "none" beat, ready returns right after.
    beats = 0;
    send_req(16'h0000, 1'b1);
    chk("empty_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk("empty_ready_back", 32'(req_ready), 32'd1);
    wait_drain("empty_drain");
    chk("empty_beats", 32'(beats), 32'd1);

    // Two corner matches, first beat one cycle after acceptance.
    beats = 0;
    send_req(16'h8001, 1'b1);
    chk("lat_valid_low", 32'(out_valid), 32'd0);
    chk("lat_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("lat_valid_high", 32'(out_valid), 32'd1);
    chk("lat_vec0",       32'(out_vec),   32'd0);
    wait_drain("corner_drain");
    chk("corner_beats", 32'(beats), 32'd2);

    // Inverted polarity: 14 middle vectors.
    beats = 0;
    send_req(16'h8001, 1'b0);
    wait_drain("inv_drain");
    chk("inv_beats", 32'(beats), 32'd14);

    // Ordering-sensitive pair (order depends on build option).
    beats = 0;
    send_req(16'h000C, 1'b1);
    wait_drain("order_drain");
    chk("order_beats", 32'(beats), 32'd2);

    // Backpressure on the beat carrying vector 3.
    beats = 0;
    send_req(16'hFFFF, 1'b1);
    n = 0;
    while (!(out_valid && out_vec == ord(3)) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_reach_beat3", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_still_vec", 32'(out_vec), 32'(ord(3)));
    out_ready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_beats", 32'(beats), 32'd16);

    // Reset while holding a beat abandons the request.
    out_ready = 1'b0;
    send_req(16'hFFFF, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_in_hold", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    q.delete();
    out_ready = 1'b1;
    beats = 0;
    send_req(16'h0001, 1'b1);
    wait_drain("post_rst_drain");
    chk("post_rst_beats", 32'(beats), 32'd1);

    // Stray request while busy has no effect.
    beats = 0;
    out_ready = 1'b0;
    send_req(16'h0030, 1'b1);
    req_tt = 16'hFFFF; req_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    req_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("busy_drain");
    chk("busy_beats", 32'(beats), 32'd2);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
